// File: rtl/uart_rx_pkg.sv
// Shared types and reset constants for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic FLAG_CLR  = 1'b0;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous level input; resets to a chosen idle value.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start-edge detect, mid-bit sampling on oversample ticks, parity and stop checks.
// state  | meaning
// IDLE   | waiting for a 1->0 line edge on a tick
// START  | counting to mid start bit, rejects glitches
// DATA   | sampling DATA_WIDTH bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then publishing the word
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  UCLK,
  input  logic                  reset,
  input  logic                  rx_serial,
  input  logic                  sample_tick,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  rx_state_e             state, state_nxt;
  logic                  rx_s;
  logic                  prev_s;
  logic [TICK_W-1:0]     tick_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  xor_data;
  logic                  perr;
  logic                  par_en_q;
  logic                  par_odd_q;
  logic                  start_edge;
  logic                  mid_hit;
  logic                  bit_hit;

  uart_rx_sync #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk   (UCLK),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

  assign start_edge = sample_tick && !rx_s && prev_s;
  assign mid_hit    = sample_tick && (tick_cnt == TICK_MID);
  assign bit_hit    = sample_tick && (tick_cnt == TICK_LAST);
  assign rx_busy    = (state != IDLE);

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (mid_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && (bit_cnt == BIT_LAST)) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_hit) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      prev_s     <= LINE_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      xor_data   <= 1'b0;
      perr       <= FLAG_CLR;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= FLAG_CLR;
      frame_err  <= FLAG_CLR;
    end else begin
      rx_valid <= 1'b0;
      if (sample_tick) prev_s <= rx_s;
      case (state)
        IDLE: begin
          if (start_edge) begin
            tick_cnt  <= '0;
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
          end
        end
        START: begin
          if (mid_hit) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            xor_data <= 1'b0;
            perr     <= FLAG_CLR;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_hit) begin
            shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            xor_data  <= xor_data ^ rx_s;
            bit_cnt   <= bit_cnt + 1'b1;
            tick_cnt  <= '0;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_hit) begin
            perr     <= ((xor_data ^ rx_s) != par_odd_q);
            tick_cnt <= '0;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          // Word and flags are published together; data is kept even on error.
          if (bit_hit) begin
            rx_data    <= shift_reg;
            parity_err <= par_en_q & perr;
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
            tick_cnt   <= '0;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: vector table of frames plus hand-written corner sequences.
module tb_uart_rx_deserializer;

  localparam int DW = 8;
  localparam int OS = 16;

  logic          UCLK = 1'b0;
  logic          reset;
  logic          rx_serial;
  logic          sample_tick;
  logic          parity_en;
  logic          parity_odd;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          parity_err;
  logic          frame_err;
  logic          rx_busy;

  uart_rx_deserializer #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .UCLK        (UCLK),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .sample_tick (sample_tick),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 UCLK = ~UCLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          pen;
    logic          podd;
    logic          pbit;
    logic          stopb;
    logic [DW-1:0] exp_data;
    logic          exp_perr;
    logic          exp_ferr;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    int            cyc;
  } mon_t;

  vec_t vecs[8];
  mon_t mq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   tick_div = 1;
  int   div_cnt = 0;
  int   start_cyc = 0;
  logic busy_seen = 1'b0;

  always @(posedge UCLK) begin
    cyc++;
    #1;
    if (rx_busy) busy_seen = 1'b1;
    if (rx_valid) mq.push_back('{rx_data, parity_err, frame_err, cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cycle();
    @(negedge UCLK);
    if (div_cnt >= tick_div - 1) begin
      div_cnt     = 0;
      sample_tick = 1'b1;
    end else begin
      div_cnt++;
      sample_tick = 1'b0;
    end
  endtask

  task automatic hold(input logic b, input int n);
    int got = 0;
    rx_serial = b;
    while (got < n) begin
      cycle();
      if (sample_tick) got++;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic stopb, input int idle_bits);
    parity_en  = pen;
    parity_odd = podd;
    start_cyc  = cyc;
    hold(1'b0, OS);
    // Scramble mode inputs mid-frame: the receiver must use the values latched at the start edge.
    parity_en  = ~pen;
    parity_odd = ~podd;
    for (int i = 0; i < DW; i++) hold(d[i], OS);
    if (pen) hold(pbit, OS);
    hold(stopb, OS);
    parity_en  = pen;
    parity_odd = podd;
    if (idle_bits > 0) hold(1'b1, idle_bits * OS);
  endtask

  initial begin
    //            data   pen   podd  pbit  stop  exp    perr  ferr
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
    vecs[5] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 8'h96, 1'b1, 1'b0};

    reset       = 1'b0;
    rx_serial   = 1'b1;
    sample_tick = 1'b0;
    parity_en   = 1'b0;
    parity_odd  = 1'b0;
    repeat (3) cycle();
    #1;
    chk("reset rx_data", 32'(rx_data), 32'h0);
    chk("reset rx_valid", 32'(rx_valid), 32'h0);
    chk("reset parity_err", 32'(parity_err), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    chk("reset rx_busy", 32'(rx_busy), 32'h0);
    reset = 1'b1;
    hold(1'b1, 2 * OS);

    for (int v = 0; v < 8; v++) begin
      mq.delete();
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].podd, vecs[v].pbit, vecs[v].stopb, 1);
      chk($sformatf("vec%0d valid count", v), 32'(mq.size()), 32'd1);
      if (mq.size() > 0) begin
        chk($sformatf("vec%0d rx_data", v), 32'(mq[0].data), 32'(vecs[v].exp_data));
        chk($sformatf("vec%0d parity_err", v), 32'(mq[0].perr), 32'(vecs[v].exp_perr));
        chk($sformatf("vec%0d frame_err", v), 32'(mq[0].ferr), 32'(vecs[v].exp_ferr));
        if (v == 0) chk("vec0 latency cycles", 32'(mq[0].cyc - start_cyc), 32'd155);
      end
    end

    // Stop bit low, then line stuck low for 40 bit-times.
    mq.delete();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    hold(1'b0, 40 * OS);
    chk("stuck valid count", 32'(mq.size()), 32'd1);
    if (mq.size() > 0) begin
      chk("stuck rx_data", 32'(mq[0].data), 32'h5A);
      chk("stuck frame_err", 32'(mq[0].ferr), 32'h1);
    end
    chk("stuck rx_busy", 32'(rx_busy), 32'h0);
    hold(1'b1, OS);
    mq.delete();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("rearm valid count", 32'(mq.size()), 32'd1);
    if (mq.size() > 0) begin
      chk("rearm rx_data", 32'(mq[0].data), 32'h3C);
      chk("rearm frame_err", 32'(mq[0].ferr), 32'h0);
    end

    // Start-bit glitch.
    mq.delete();
    busy_seen = 1'b0;
    hold(1'b0, 4);
    hold(1'b1, 2 * OS);
    chk("glitch busy pulse", 32'(busy_seen), 32'h1);
    chk("glitch valid count", 32'(mq.size()), 32'd0);
    chk("glitch rx_busy after", 32'(rx_busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("post-glitch valid count", 32'(mq.size()), 32'd1);
    if (mq.size() > 0) chk("post-glitch rx_data", 32'(mq[0].data), 32'h81);

    // Reset in the middle of DATA.
    mq.delete();
    parity_en = 1'b0;
    hold(1'b0, OS);
    hold(1'b1, 3 * OS + 4);
    chk("pre-reset rx_busy", 32'(rx_busy), 32'h1);
    reset = 1'b0;
    repeat (3) cycle();
    #1;
    chk("midreset rx_data", 32'(rx_data), 32'h0);
    chk("midreset rx_busy", 32'(rx_busy), 32'h0);
    chk("midreset rx_valid", 32'(rx_valid), 32'h0);
    reset = 1'b1;
    hold(1'b1, 12 * OS);
    chk("midreset valid count", 32'(mq.size()), 32'd0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("post-reset valid count", 32'(mq.size()), 32'd1);
    if (mq.size() > 0) begin
      chk("post-reset rx_data", 32'(mq[0].data), 32'h00);
      chk("post-reset errors", 32'({mq[0].perr, mq[0].ferr}), 32'h0);
    end

    // Back-to-back frames, tick every third cycle.
    tick_div = 3;
    div_cnt  = 0;
    hold(1'b1, 2 * OS);
    mq.delete();
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("b2b valid count", 32'(mq.size()), 32'd2);
    if (mq.size() > 1) begin
      chk("b2b first rx_data", 32'(mq[0].data), 32'h11);
      chk("b2b second rx_data", 32'(mq[1].data), 32'h22);
      chk("b2b errors", 32'({mq[0].perr, mq[0].ferr, mq[1].perr, mq[1].ferr}), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
